layer0_window_gen: RTL
======================

// Module: layer0_window_gen
// PURPOSE
//  Parametrised 3x3 sliding-window generator for the convolution front end. Reads pixels from
//  external image memory in raster order and emits one 9-pixel window per output pixel on a
//  valid/ready handshake to the downstream kernal stage. Generalises the fixed 64x64/20-bit
//  fetcher with configurable image size, pixel width, border padding and backpressure.
// PARAMETERS
//  DATA_W  20  pixel width in bits
//  IMG_W   64  image width in pixels (>=2)
//  IMG_H   64  image height in pixels (>=2)
//  ADDR_W  12  memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk       in   1          single clock, all logic on rising edge
//  reset     in   1          synchronous, active-high
//  i_start   in   1          one-cycle start pulse; ignored while o_busy=1
//  o_busy    out  1          high from the cycle after accepted i_start until o_done
//  o_addr    out  ADDR_W     memory read address = row*IMG_W+col
//  i_data    in   DATA_W     memory data, valid exactly 1 cycle after o_addr
//  o_valid   out  1          window available
//  i_ready   in   1          downstream accepts window when o_valid&i_ready
//  o_window  out  9*DATA_W   pixel (wr,wc) at [DATA_W*(3*wr+wc) +: DATA_W]; wr0=top, wc0=left
//  o_row     out  ADDR_W/2+1 centre row of o_window
//  o_col     out  ADDR_W/2+1 centre column of o_window
//  o_done    out  1          one-cycle pulse after last window handshake
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, window regs 0. Reset mid-scan aborts; no o_done.
//  - FSM: IDLE -> LOAD_L -> LOAD_C -> LOAD_R -> EMIT -> (LOAD_R | LOAD_L | DONE) -> IDLE.
//  - IDLE: on i_start, o_busy<=1, row=0, col=0, go LOAD_L.
//  - Column load (LOAD_L/C/R): 4 cycles; o_addr issued for rows r-1,r,r+1 in cycles 0..2,
//    data captured cycles 1..3 into the target window column. Coordinate outside image:
//    address still issued (clamped into range), captured value replaced by padding.
//  - LOAD_L loads column c-1, LOAD_C column c, LOAD_R column c+1; then EMIT.
//  - EMIT: o_valid=1, o_window/o_row/o_col stable until handshake; o_addr held.
//    On o_valid&i_ready: o_valid<=0 next cycle; window shifts left (wc0<=wc1, wc1<=wc2).
//    If col<IMG_W-1: col++, go LOAD_R. Else if row<IMG_H-1: col=0, row++, go LOAD_L.
//    Else go DONE.
//  - DONE: o_done=1 for one cycle, o_busy<=0, return IDLE.
//  - i_ready high with o_valid low has no effect. i_start while busy ignored.
//  - Throughput with i_ready=1: 5 cycles/window, plus 8 cycles per row start.
//  - Padding default: zero.
// CONFIGURATION
//  LAYER0_REPLICATE_PAD_EN defined: out-of-image coordinates clamp to nearest edge pixel and
//   the fetched value is used (edge replication). Undefined: out-of-image pixels read as 0.
//   Cycle timing identical in both builds.
// TESTING (IMG_W=IMG_H=4, ADDR_W=4, memory word at addr a = a+1, i_ready=1 unless stated)
//  1. Corner (0,0), zero pad -> first o_window = {0,0,0, 0,1,2, 0,5,6} (wr0..wr2 order), o_row=o_col=0.
//  2. Interior (1,1) -> o_window = {1,2,3, 5,6,7, 9,10,11}; (3,3) -> {11,12,0, 15,16,0, 0,0,0}.
//  3. i_ready low 5 cycles at window 2 -> o_valid held high, o_window and o_addr constant; resumes unchanged.
//  4. Full scan -> exactly 16 handshakes in raster order; o_done one pulse; o_busy low next cycle.
//  5. reset asserted during window 6 -> next cycle o_busy=o_valid=o_addr=0; new i_start rescans from (0,0).
//  6. LAYER0_REPLICATE_PAD_EN defined -> (0,0) window = {1,1,2, 1,1,2, 5,5,6}.

Source files
------------

// File: rtl/layer0_window_gen.sv
// layer0_window_gen: 3x3 sliding-window generator for the convolution front end.
// Fetches pixels in raster order from external memory (1-cycle read latency) and
// presents one 9-pixel window per image pixel on a valid/ready handshake.
// Optional build macro: LAYER0_REPLICATE_PAD_EN selects edge replication instead
// of zero padding for out-of-image coordinates (cycle timing is identical).
module layer0_window_gen #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic [ADDR_W-1:0]       o_addr,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [9*DATA_W-1:0]     o_window,
    output logic [ADDR_W/2:0]       o_row,
    output logic [ADDR_W/2:0]       o_col,
    output logic                    o_done
);

    localparam int unsigned CW = ADDR_W / 2 + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_L = 3'd1,
        S_LOAD_C = 3'd2,
        S_LOAD_R = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [CW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [9*DATA_W-1:0] win_q, win_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    // Helpers for the column currently being loaded and the pixel being captured
    int                  col_off;
    int                  tgt_wc;
    int                  cap_r;
    int                  cap_c;
    int                  cap_wr;
    logic [DATA_W-1:0]   cap_val;

    // Clamp an image coordinate into range and form its memory address
    function automatic logic [ADDR_W-1:0] addr_of(input int r, input int c);
        int rc;
        int cc;
        rc = (r < 0) ? 0 : ((r > int'(IMG_H) - 1) ? int'(IMG_H) - 1 : r);
        cc = (c < 0) ? 0 : ((c > int'(IMG_W) - 1) ? int'(IMG_W) - 1 : c);
        return ADDR_W'(rc * int'(IMG_W) + cc);
    endfunction

`ifndef LAYER0_REPLICATE_PAD_EN
    // True when a coordinate lies inside the image
    function automatic logic in_img(input int r, input int c);
        return (r >= 0) && (r < int'(IMG_H)) && (c >= 0) && (c < int'(IMG_W));
    endfunction
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        win_d   = win_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        col_off = 0;
        tgt_wc  = 1;
        cap_wr  = 0;
        cap_r   = 0;
        cap_c   = 0;
        cap_val = '0;

        case (state_q)
            S_LOAD_L: begin col_off = -1; tgt_wc = 0; end
            S_LOAD_R: begin col_off = 1;  tgt_wc = 2; end
            default:  begin col_off = 0;  tgt_wc = 1; end
        endcase

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    busy_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                    addr_d  = addr_of(-1, -1);
                    state_d = S_LOAD_L;
                end
            end

            S_LOAD_L, S_LOAD_C, S_LOAD_R: begin
                // Cycles 1..3 capture the word addressed in the previous cycle
                if (cnt_q != 2'd0) begin
                    cap_wr = int'(cnt_q) - 1;
                    cap_r  = int'(row_q) - 1 + cap_wr;
                    cap_c  = int'(col_q) + col_off;
`ifdef LAYER0_REPLICATE_PAD_EN
                    cap_val = i_data;
`else
                    cap_val = in_img(cap_r, cap_c) ? i_data : '0;
`endif
                    win_d[DATA_W*(3*cap_wr + tgt_wc) +: DATA_W] = cap_val;
                end
                if (cnt_q != 2'd3) begin
                    cnt_d = cnt_q + 2'd1;
                    // Cycles 0..2 present rows r-1, r, r+1
                    if (cnt_q != 2'd2) begin
                        addr_d = addr_of(int'(row_q) + int'(cnt_q), int'(col_q) + col_off);
                    end
                end else begin
                    cnt_d = '0;
                    case (state_q)
                        S_LOAD_L: begin
                            state_d = S_LOAD_C;
                            addr_d  = addr_of(int'(row_q) - 1, int'(col_q));
                        end
                        S_LOAD_C: begin
                            state_d = S_LOAD_R;
                            addr_d  = addr_of(int'(row_q) - 1, int'(col_q) + 1);
                        end
                        default: begin
                            state_d = S_EMIT;
                            valid_d = 1'b1;
                        end
                    endcase
                end
            end

            S_EMIT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    for (int wr = 0; wr < 3; wr++) begin
                        win_d[DATA_W*(3*wr)     +: DATA_W] = win_q[DATA_W*(3*wr + 1) +: DATA_W];
                        win_d[DATA_W*(3*wr + 1) +: DATA_W] = win_q[DATA_W*(3*wr + 2) +: DATA_W];
                    end
                    if (col_q < CW'(IMG_W - 1)) begin
                        col_d   = col_q + CW'(1);
                        addr_d  = addr_of(int'(row_q) - 1, int'(col_q) + 2);
                        state_d = S_LOAD_R;
                    end else if (row_q < CW'(IMG_H - 1)) begin
                        col_d   = '0;
                        row_d   = row_q + CW'(1);
                        addr_d  = addr_of(int'(row_q), -1);
                        state_d = S_LOAD_L;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy   = busy_q;
    assign o_addr   = addr_q;
    assign o_valid  = valid_q;
    assign o_window = win_q;
    assign o_row    = row_q;
    assign o_col    = col_q;
    assign o_done   = done_q;

endmodule
